// File: rtl/shiftreg_frame.sv
// shiftreg_frame: universal shift register (left/right, shift/rotate) with a
// WIDTH-shift frame serialiser that reports busy, done and shift count.
module shiftreg_frame #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             sclr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             dir,
  input  logic             rotate,
  input  logic             shiftin,
  output logic [WIDTH-1:0] q,
  output logic             shiftout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_count;
  logic             r_done;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_done_nxt;
  logic             w_busy;
  logic             w_fill_bit;
  logic [WIDTH-1:0] w_q_shifted;
  logic             w_last_shift;

  assign w_busy       = (r_state == ST_BUSY);
  assign w_last_shift = (r_count == CNT_W'(WIDTH - 1));

  // One shift step in the selected direction; rotate recirculates the outgoing bit.
  always_comb begin
    w_fill_bit  = shiftin;
    w_q_shifted = r_q;
    if (dir == 1'b0) begin
      w_fill_bit  = rotate ? r_q[WIDTH-1] : shiftin;
      w_q_shifted = {r_q[WIDTH-2:0], w_fill_bit};
    end else begin
      w_fill_bit  = rotate ? r_q[0] : shiftin;
      w_q_shifted = {w_fill_bit, r_q[WIDTH-1:1]};
    end
  end

  // Next-state logic: sclr > hold > start > load > shift.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    if (sclr) begin
      w_state_nxt = ST_IDLE;
      w_q_nxt     = '0;
      w_count_nxt = '0;
    end else if (!en) begin
      w_state_nxt = r_state;
    end else if (start && !w_busy) begin
      w_state_nxt = ST_BUSY;
      w_q_nxt     = data;
      w_count_nxt = '0;
    end else if (load && !w_busy) begin
      w_q_nxt     = data;
    end else begin
      w_q_nxt = w_q_shifted;
      if (w_busy) begin
        w_count_nxt = r_count + CNT_W'(1);
        if (w_last_shift) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign q        = r_q;
  assign busy     = w_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign shiftout = dir ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: tb/tb_shiftreg_frame.sv
// Directed testbench for shiftreg_frame (WIDTH=8).
module tb_shiftreg_frame;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             clrn;
  logic             sclr;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             start;
  logic             dir;
  logic             rotate;
  logic             shiftin;
  logic [WIDTH-1:0] q;
  logic             shiftout;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  shiftreg_frame #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clrn(clrn), .sclr(sclr), .en(en), .load(load), .data(data),
    .start(start), .dir(dir), .rotate(rotate), .shiftin(shiftin),
    .q(q), .shiftout(shiftout), .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sclr = 0; en = 1; load = 0; start = 0; data = '0;
    dir = 0; rotate = 0; shiftin = 0;
  endtask

  task automatic test_reset();
    clrn = 1;
    sclr = 0; en = 1'($urandom); load = 1'($urandom); start = 1'($urandom);
    data = 8'($urandom); dir = 1'($urandom); rotate = 1'($urandom); shiftin = 1'($urandom);
    #2 clrn = 0;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 || shiftout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: q=%h busy=%b done=%b count=%0d so=%b, required all 0", q, busy, done, count, shiftout);
    end
    repeat (3) tick();
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_held: q=%h busy=%b count=%0d, required 0", q, busy, count);
    end
    idle_inputs();
    en = 0;
    @(negedge clk);
    clrn = 1;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release: q=%h busy=%b done=%b count=%0d, required 0", q, busy, done, count);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_left_shift();
    logic [2:0] exp_so;
    exp_so = 3'b100;
    load = 1; data = 8'h81;
    tick();
    load = 0; data = '0;
    n_checks++;
    if (q !== 8'h81) begin
      n_fail++;
      $display("FAIL left_load: q=%h, required 81", q);
    end
    dir = 0; rotate = 0; shiftin = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (shiftout !== exp_so[2-i]) begin
        n_fail++;
        $display("FAIL left_shiftout%0d: got %b, required %b", i, shiftout, exp_so[2-i]);
      end
      tick();
    end
    n_checks++;
    if (q !== 8'h0F || count !== 4'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL left_final: q=%h count=%0d busy=%b, required 0f 0 0", q, count, busy);
    end
    idle_inputs();
  endtask

  task automatic test_rotate_right();
    load = 1; data = 8'hA5;
    tick();
    load = 0;
    dir = 1; rotate = 1;
    for (int i = 0; i < 4; i++) begin
      shiftin = 1'(i);
      tick();
    end
    n_checks++;
    if (q !== 8'h5A) begin
      n_fail++;
      $display("FAIL rotate_right: q=%h, required 5a", q);
    end
    dir = 0;
    tick();
    n_checks++;
    if (q !== 8'hB4) begin
      n_fail++;
      $display("FAIL rotate_left: q=%h, required b4", q);
    end
    idle_inputs();
  endtask

  task automatic test_frame_stall();
    logic [7:0] exp_bits;
    int k, busy_cycles, done_pulses;
    exp_bits = 8'hC3;
    k = 0; busy_cycles = 0; done_pulses = 0;
    start = 1; data = 8'hC3;
    tick();
    start = 0; data = '0;
    n_checks++;
    if (busy !== 1'b1 || q !== 8'hC3 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL frame_start: busy=%b q=%h count=%0d, required 1 c3 0", busy, q, count);
    end
    for (int i = 0; i < 10; i++) begin
      if (busy === 1'b1) busy_cycles++;
      en = (i == 3 || i == 4) ? 1'b0 : 1'b1;
      if (en) begin
        n_checks++;
        if (shiftout !== exp_bits[7-k]) begin
          n_fail++;
          $display("FAIL frame_bit%0d: shiftout=%b, required %b", k, shiftout, exp_bits[7-k]);
        end
        k++;
      end
      tick();
      if (done === 1'b1) done_pulses++;
    end
    en = 1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1 || count !== 4'd8 || busy_cycles != 10 || done_pulses != 1) begin
      n_fail++;
      $display("FAIL frame_end: busy=%b done=%b count=%0d busy_cyc=%0d pulses=%0d, required 0 1 8 10 1",
               busy, done, count, busy_cycles, done_pulses);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || count !== 4'd8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_after: done=%b count=%0d busy=%b, required 0 8 0", done, count, busy);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    int done_seen;
    done_seen = 0;
    start = 1; data = 8'h3C;
    tick();
    start = 0;
    repeat (5) tick();
    n_checks++;
    if (count !== 4'd5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre: count=%0d busy=%b, required 5 1", count, busy);
    end
    sclr = 1;
    tick();
    sclr = 0;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || count !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: q=%h busy=%b count=%0d done=%b, required 0", q, busy, count, done);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done === 1'b1) done_seen++;
    end
    n_checks++;
    if (done_seen != 0) begin
      n_fail++;
      $display("FAIL abort_nodone: %0d done pulses, required 0", done_seen);
    end
    idle_inputs();
  endtask

  task automatic test_ignored_requests();
    logic [7:0] exp_q [8];
    exp_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00};
    start = 1; data = 8'h81;
    tick();
    start = 1; load = 1; data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (q !== exp_q[i] || count !== CNT_W'(i + 1)) begin
        n_fail++;
        $display("FAIL ignored_shift%0d: q=%h count=%0d, required %h %0d", i, q, count, exp_q[i], i + 1);
      end
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_done: done=%b busy=%b, required 1 0", done, busy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || q !== 8'hFF || count !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: busy=%b q=%h count=%0d done=%b, required 1 ff 0 0", busy, q, count, done);
    end
    idle_inputs();
    sclr = 1;
    tick();
    sclr = 0;
  endtask

  task automatic test_async_reset_mid_frame();
    start = 1; data = 8'hE7;
    tick();
    start = 0;
    repeat (3) tick();
    #1 clrn = 0;
    #1;
    n_checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 || shiftout !== 1'b0) begin
      n_fail++;
      $display("FAIL async_mid: q=%h busy=%b done=%b count=%0d so=%b, required 0", q, busy, done, count, shiftout);
    end
    @(negedge clk);
    clrn = 1;
  endtask

  initial begin
    test_reset();
    test_left_shift();
    test_rotate_right();
    test_frame_stall();
    test_abort();
    test_ignored_requests();
    test_async_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shiftreg_frame.md
# shiftreg_frame

Parametrised universal shift register with a built-in frame serialiser. It is the successor to the fixed-width enable/load/serial-in shift register. It adds:
- generic width;
- selectable shift direction;
- rotate mode;
- an automatic WIDTH-bit frame engine with busy/done status.

It sits between bus-side parallel registers and serial links or test outputs, and can act as a plain shift register or as a serialiser.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the frame shift counter; derived, not to be overridden.

- clk  in  1  rising-edge clock.
- clrn  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear; acts regardless of en.
- en  in  1  clock enable for load, start and shift.
- load  in  1  parallel load of data (ignored while busy).
- data  in  WIDTH  parallel load value.
- start  in  1  load data and begin a WIDTH-shift frame.
- dir  in  1  0 = shift toward MSB (left), 1 = shift toward LSB (right).
- rotate  in  1  1 = the bit shifted out re-enters at the opposite end; shiftin is ignored.
- shiftin  in  1  serial input bit.
- q  out  WIDTH  register contents.
- shiftout  out  1  combinational: q[WIDTH-1] when dir=0, q[0] when dir=1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- count  out  CNT_W  shifts completed in the current frame.

## Operation
- Priority at each rising edge of clk, highest first:
  1. sclr=1: q=0, busy=0, count=0, done=0. This aborts any frame and gives no done pulse.
  2. en=0: hold all state; done is forced to 0.
  3. start=1 and busy=0: q=data, busy=1, count=0.
  4. load=1 and busy=0: q=data, count unchanged.
  5. Otherwise: one shift step.
- Shift left (dir=0): q = {q[WIDTH-2:0], b}, where b = rotate ? q[WIDTH-1] : shiftin.
- Shift right (dir=1): q = {b, q[WIDTH-1:1]}, where b = rotate ? q[0] : shiftin.
- While busy=1, start and load are ignored. Every enabled shift increments count.
- Shift number WIDTH completes the frame. On that same edge busy becomes 0, count stays at WIDTH and done is 1 for exactly one cycle.
- count keeps its final value until the next start or sclr. Shifts outside a frame do not change count.
- dir and rotate are sampled every shift and may change mid-frame.
- done is 0 on every edge except the frame-completing edge.

## Timing
- Reset state (clrn=0, asynchronous): q=0, busy=0, done=0, count=0. shiftout=0.
- On clrn release, state is held until the first rising edge of clk.
- Load latency: q shows data one edge after load or start is sampled.
- shiftout has zero latency from q and dir; it is combinational.
- Frame length with en held at 1: start sampled at edge 0; shifts occur at edges 1..WIDTH; busy is high from after edge 0 until edge WIDTH; done is high for the cycle after edge WIDTH.
- With en deasserted during a frame, frame length is WIDTH enabled cycles plus the stall cycles. busy stays at 1 through stalls.
- start on the frame-completing edge is ignored, because busy=1 when it is sampled. The earliest restart is one cycle later; done=1 and start=1 together start a new frame.
- Asynchronous clrn mid-frame returns all outputs to reset values immediately.

## Test plan
- Reset: assert clrn=0 with random inputs -> q=0, busy=0, done=0, count=0 and shiftout=0 with no clock edge. They stay there until the first edge after release.
- Left shift, WIDTH=8: load 8'h81, then 3 shifts with shiftin=1, dir=0, rotate=0 -> q=8'h0F. The shiftout sequence before each shift is 1, 0, 0.
- Right rotate: load 8'hA5, then 4 shifts with dir=1, rotate=1 -> q=8'h5A; shiftin toggling has no effect.
- Frame with stalls: start with data=8'hC3, dir=0, en low for 2 cycles mid-frame -> shiftout serialises 1,1,0,0,0,0,1,1. busy is high for 10 cycles, done pulses once, and count ends at 8.
- Abort: sclr at count=5 -> q=0, busy=0, count=0 next edge; no done pulse is ever produced for that frame.
- Ignored requests: during a frame, drive start=1 and load=1 with data=8'hFF -> q continues shifting and count advances normally. A start on the done cycle begins a new frame with busy=1 on the following cycle.
